// File: rtl/screen_mem_pkg.sv
// Shared types and default geometry for the text-mode screen memory arbiter.
package screen_mem_pkg;

    localparam int DEF_DATA_WIDTH   = 7;
    localparam int DEF_ADDR_WIDTH   = 11;
    localparam int DEF_COLS         = 80;
    localparam int DEF_ROWS         = 25;
    localparam int DEF_STARVE_LIMIT = 4;

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_DISP = 2'd1,
        OWN_HOST = 2'd2
    } owner_t;

endpackage

// File: rtl/scroll_addr_map.sv
// Logical (row-major) display address to physical address, rotated by the scroll row.
module scroll_addr_map #(
    parameter int ADDR_WIDTH = 11,
    parameter int COLS       = 80,
    parameter int ROWS       = 25,
    parameter int ROW_W      = $clog2(ROWS)
) (
    input  logic [ROW_W-1:0]      scroll_row,
    input  logic [ADDR_WIDTH-1:0] logical_addr,
    output logic [ADDR_WIDTH-1:0] phys_addr
);

    localparam int SUM_W = ADDR_WIDTH + 1;
    localparam logic [SUM_W-1:0] COLS_S   = SUM_W'(COLS);
    localparam logic [SUM_W-1:0] ROWS_S   = SUM_W'(ROWS);
    localparam logic [SUM_W-1:0] SCREEN_S = SUM_W'(COLS * ROWS);

    logic [SUM_W-1:0] row_eff;
    logic [SUM_W-1:0] offset;
    logic [SUM_W-1:0] sum;
    logic [SUM_W-1:0] wrapped;

    always_comb begin
        // Out-of-range scroll values fall back to no rotation.
        row_eff   = (SUM_W'(scroll_row) >= ROWS_S) ? '0 : SUM_W'(scroll_row);
        offset    = row_eff * COLS_S;
        sum       = SUM_W'(logical_addr) + offset;
        wrapped   = (sum >= SCREEN_S) ? (sum - SCREEN_S) : sum;
        phys_addr = ADDR_WIDTH'(wrapped);
    end

endmodule

// File: rtl/screen_mem_arbiter.sv
// Display-priority arbiter for the screen memory read port, with a starvation
// guard for the host and registered read data per requester.
module screen_mem_arbiter
    import screen_mem_pkg::*;
#(
    parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter int COLS         = DEF_COLS,
    parameter int ROWS         = DEF_ROWS,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    disp_req,
    input  logic [ADDR_WIDTH-1:0]   disp_addr,
    output logic                    disp_ready,
    output logic                    disp_valid,
    output logic [DATA_WIDTH-1:0]   disp_data,
    input  logic                    host_req,
    input  logic [ADDR_WIDTH-1:0]   host_addr,
    output logic                    host_ready,
    output logic                    host_valid,
    output logic [DATA_WIDTH-1:0]   host_data,
    input  logic [$clog2(ROWS)-1:0] scroll_row,
    output logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic [DATA_WIDTH-1:0]   mem_data
);

    localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [ADDR_WIDTH-1:0] disp_phys;
    owner_t                owner;

    logic [CNT_W-1:0]      starve_cnt_q, starve_cnt_d;
    logic                  disp_valid_q, disp_valid_d;
    logic                  host_valid_q, host_valid_d;
    logic [DATA_WIDTH-1:0] disp_data_q,  disp_data_d;
    logic [DATA_WIDTH-1:0] host_data_q,  host_data_d;

    scroll_addr_map #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .COLS       (COLS),
        .ROWS       (ROWS)
    ) u_scroll_addr_map (
        .scroll_row   (scroll_row),
        .logical_addr (disp_addr),
        .phys_addr    (disp_phys)
    );

    // Owner decode and starvation counter; the counter only survives a cycle
    // in which the host asked and lost to the display.
    always_comb begin
        owner        = OWN_NONE;
        starve_cnt_d = '0;
        if (reset) begin
            owner = OWN_NONE;
        end else if (host_req && (starve_cnt_q == CNT_W'(STARVE_LIMIT))) begin
            owner = OWN_HOST;
        end else if (disp_req) begin
            owner = OWN_DISP;
            if (host_req) begin
                starve_cnt_d = starve_cnt_q + CNT_W'(1);
            end
        end else if (host_req) begin
            owner = OWN_HOST;
        end
    end

    always_comb begin
        disp_ready = (owner == OWN_DISP);
        host_ready = (owner == OWN_HOST);
        unique case (owner)
            OWN_DISP: mem_addr = disp_phys;
            OWN_HOST: mem_addr = host_addr;
            default:  mem_addr = '0;
        endcase
    end

    always_comb begin
        disp_valid_d = disp_ready;
        host_valid_d = host_ready;
        disp_data_d  = disp_ready ? mem_data : disp_data_q;
        host_data_d  = host_ready ? mem_data : host_data_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            starve_cnt_q <= '0;
            disp_valid_q <= 1'b0;
            host_valid_q <= 1'b0;
            disp_data_q  <= '0;
            host_data_q  <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            disp_valid_q <= disp_valid_d;
            host_valid_q <= host_valid_d;
            disp_data_q  <= disp_data_d;
            host_data_q  <= host_data_d;
        end
    end

    assign disp_valid = disp_valid_q;
    assign host_valid = host_valid_q;
    assign disp_data  = disp_data_q;
    assign host_data  = host_data_q;

endmodule

// File: tb/tb_screen_mem_arbiter.sv
// Directed-vector bench for screen_mem_arbiter with a behavioural screen memory.
module tb_screen_mem_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        disp_req;
    logic [10:0] disp_addr;
    logic        disp_ready;
    logic        disp_valid;
    logic [6:0]  disp_data;
    logic        host_req;
    logic [10:0] host_addr;
    logic        host_ready;
    logic        host_valid;
    logic [6:0]  host_data;
    logic [4:0]  scroll_row;
    logic [10:0] mem_addr;
    logic [6:0]  mem_data;

    logic [6:0]  mem [0:2047];

    int n_vec = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    assign mem_data = mem[mem_addr];

    screen_mem_arbiter dut (
        .clock      (clock),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_ready (disp_ready),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .host_req   (host_req),
        .host_addr  (host_addr),
        .host_ready (host_ready),
        .host_valid (host_valid),
        .host_data  (host_data),
        .scroll_row (scroll_row),
        .mem_addr   (mem_addr),
        .mem_data   (mem_data)
    );

    function automatic logic [6:0] mem_val(input int a);
        if (a == 5) return 7'h41;
        return 7'((a * 3) + 1);
    endfunction

    task automatic check_val(input string tag, input int got, input int exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Runs n cycles of continuous contention; grant k (1-based) goes to the
    // host when k is a multiple of five, as the counter restarts each time.
    task automatic contend(input int n, input string tag);
        int prev_h;
        prev_h = -1;
        disp_req  = 1'b1;
        host_req  = 1'b1;
        for (int i = 0; i < n; i++) begin
            int exp_h;
            exp_h = ((i % 5) == 4) ? 1 : 0;
            #1;
            check_val($sformatf("%s host_ready[%0d]", tag, i), int'(host_ready), exp_h);
            check_val($sformatf("%s disp_ready[%0d]", tag, i), int'(disp_ready), 1 - exp_h);
            step();
            check_val($sformatf("%s host_valid[%0d]", tag, i), int'(host_valid), exp_h);
            check_val($sformatf("%s disp_valid[%0d]", tag, i), int'(disp_valid), 1 - exp_h);
            if (exp_h == 1) begin
                check_val($sformatf("%s host_data[%0d]", tag, i), int'(host_data), int'(mem_val(7)));
            end
            prev_h = exp_h;
        end
    endtask

    initial begin
        for (int a = 0; a < 2048; a++) begin
            mem[a] = mem_val(a);
        end

        // Reset with both requests active: no grants, no memory address.
        reset      = 1'b1;
        disp_req   = 1'b1;
        host_req   = 1'b1;
        disp_addr  = 11'd12;
        host_addr  = 11'd5;
        scroll_row = 5'd0;
        #2;
        check_val("rst disp_ready", int'(disp_ready), 0);
        check_val("rst host_ready", int'(host_ready), 0);
        check_val("rst mem_addr", int'(mem_addr), 0);
        step();
        check_val("rst disp_valid", int'(disp_valid), 0);
        check_val("rst host_valid", int'(host_valid), 0);
        check_val("rst disp_data", int'(disp_data), 0);
        check_val("rst host_data", int'(host_data), 0);
        reset    = 1'b0;
        disp_req = 1'b0;
        host_req = 1'b0;
        step();

        // Host only read of address 5.
        host_req  = 1'b1;
        host_addr = 11'd5;
        #1;
        check_val("host host_ready", int'(host_ready), 1);
        check_val("host disp_ready", int'(disp_ready), 0);
        check_val("host mem_addr", int'(mem_addr), 5);
        step();
        host_req = 1'b0;
        check_val("host host_valid", int'(host_valid), 1);
        check_val("host host_data", int'(host_data), 'h41);
        check_val("host disp_valid", int'(disp_valid), 0);
        step();
        check_val("host valid drop", int'(host_valid), 0);
        check_val("host data hold", int'(host_data), 'h41);

        // Scroll mapping: wrap, no-wrap boundary, out-of-range scroll.
        disp_req   = 1'b1;
        disp_addr  = 11'd80;
        scroll_row = 5'd24;
        #1;
        check_val("scroll24 disp_ready", int'(disp_ready), 1);
        check_val("scroll24 mem_addr", int'(mem_addr), 0);
        step();
        check_val("scroll24 disp_valid", int'(disp_valid), 1);
        check_val("scroll24 disp_data", int'(disp_data), int'(mem_val(0)));
        disp_addr = 11'd79;
        #1;
        check_val("scroll24 edge mem_addr", int'(mem_addr), 1999);
        step();
        check_val("scroll24 edge disp_valid", int'(disp_valid), 1);
        check_val("scroll24 edge disp_data", int'(disp_data), int'(mem_val(1999)));
        disp_addr  = 11'd80;
        scroll_row = 5'd30;
        #1;
        check_val("scroll30 mem_addr", int'(mem_addr), 80);
        step();
        check_val("scroll30 disp_data", int'(disp_data), int'(mem_val(80)));
        disp_addr  = 11'd10;
        scroll_row = 5'd3;
        #1;
        check_val("scroll3 mem_addr", int'(mem_addr), 250);
        step();
        check_val("scroll3 disp_data", int'(disp_data), int'(mem_val(250)));
        disp_req   = 1'b0;
        scroll_row = 5'd0;
        disp_addr  = 11'd0;
        step();

        // Sustained contention: D,D,D,D,H repeated.
        host_addr = 11'd7;
        contend(10, "cont");
        disp_req = 1'b0;
        host_req = 1'b0;
        step();

        // Simultaneous single requests at a cleared counter.
        disp_req  = 1'b1;
        host_req  = 1'b1;
        disp_addr = 11'd3;
        host_addr = 11'd9;
        #1;
        check_val("simul disp_ready", int'(disp_ready), 1);
        check_val("simul host_ready", int'(host_ready), 0);
        step();
        disp_req = 1'b0;
        #1;
        check_val("simul host_ready next", int'(host_ready), 1);
        check_val("simul mem_addr next", int'(mem_addr), 9);
        check_val("simul disp_data", int'(disp_data), int'(mem_val(3)));
        step();
        host_req = 1'b0;
        check_val("simul host_valid", int'(host_valid), 1);
        check_val("simul host_data", int'(host_data), int'(mem_val(9)));
        step();

        // Reset in a host grant cycle after the counter has advanced.
        disp_req  = 1'b1;
        host_req  = 1'b1;
        disp_addr = 11'd0;
        host_addr = 11'd7;
        step();
        step();
        disp_req  = 1'b0;
        host_addr = 11'd5;
        reset     = 1'b1;
        #1;
        check_val("mid-rst host_ready", int'(host_ready), 0);
        check_val("mid-rst mem_addr", int'(mem_addr), 0);
        step();
        reset = 1'b0;
        check_val("mid-rst host_valid", int'(host_valid), 0);
        check_val("mid-rst host_data", int'(host_data), 0);
        check_val("mid-rst disp_data", int'(disp_data), 0);
        check_val("mid-rst disp_valid", int'(disp_valid), 0);
        host_addr = 11'd7;
        contend(5, "post-rst");
        disp_req = 1'b0;
        host_req = 1'b0;

        // Idle.
        #1;
        check_val("idle mem_addr", int'(mem_addr), 0);
        check_val("idle disp_ready", int'(disp_ready), 0);
        check_val("idle host_ready", int'(host_ready), 0);
        step();
        check_val("idle disp_valid", int'(disp_valid), 0);
        check_val("idle host_valid", int'(host_valid), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/screen_mem_arbiter.md
# screen_mem_arbiter

Arbitrates the single read port of the text-mode screen memory (7-bit character codes, 11-bit address) between two requesters: the display refresh fetcher and a host reader (cursor/debug logic). The display has priority, and a starvation counter guarantees host progress. Display addresses are logical (row-major, COLS×ROWS) and are rotated by a hardware scroll offset before reaching memory. The block sits between the requesters and the screen memory instance and registers all returned data.

## Interface
- DATA_WIDTH, 7, character code width
- ADDR_WIDTH, 11, memory address width
- COLS, 80, characters per row
- ROWS, 25, rows per screen; COLS*ROWS ≤ 2**ADDR_WIDTH
- STARVE_LIMIT, 4, consecutive host-losing cycles before the host is forced through
- clock  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- disp_req  in  1  display read request
- disp_addr  in  ADDR_WIDTH  logical display address, < COLS*ROWS
- disp_ready  out  1  display granted this cycle (combinational)
- disp_valid  out  1  disp_data valid (registered)
- disp_data  out  DATA_WIDTH  registered read data
- host_req  in  1  host read request, held with stable host_addr until host_ready
- host_addr  in  ADDR_WIDTH  physical address, no scroll applied
- host_ready  out  1  host granted this cycle (combinational)
- host_valid  out  1  host_data valid (registered)
- host_data  out  DATA_WIDTH  registered read data
- scroll_row  in  $clog2(ROWS)  first displayed row
- mem_addr  out  ADDR_WIDTH  to memory address input
- mem_data  in  DATA_WIDTH  from memory data output (combinational read)

## Operation
- At most one grant per cycle. The owner of the port is one of OWN_NONE, OWN_DISP, OWN_HOST.
- Default rule: if disp_req is high, the display wins. Otherwise, if host_req is high, the host wins. Otherwise the owner is OWN_NONE.
- Starvation: starve_cnt increments on each cycle with host_req=1, disp_req=1 and the display granted.
- When starve_cnt == STARVE_LIMIT and host_req=1, the host wins regardless of disp_req, and starve_cnt clears.
- starve_cnt also clears on any host grant and on any cycle with host_req=0.
- A display request that loses stays pending. The requester holds disp_req and disp_addr until disp_ready.
- Display physical address = disp_addr + scroll_row*COLS. If the sum is ≥ COLS*ROWS, subtract COLS*ROWS (single conditional subtract; compute at ADDR_WIDTH+1 bits).
- scroll_row ≥ ROWS is treated as 0.
- mem_addr carries the winner's physical address. When the owner is OWN_NONE, mem_addr is 0.
- The *_ready signals are decoded from the owner and depend only on inputs and starve_cnt. There are no combinational paths from mem_data to any output.

## Timing
- Grant in cycle N: the matching *_ready is high in N, and mem_addr is driven in N. mem_data is captured at the end of N into *_data, and *_valid is high for exactly cycle N+1.
- Read latency: 1 cycle from grant.
- Back-to-back grants to the same requester give continuous valid.
- The unselected *_valid is 0. *_data holds its last value when not valid.
- Reset (synchronous, any cycle, including mid-request): in the following cycle disp_valid=host_valid=0, disp_data=host_data=0, and starve_cnt=0.
  - During reset cycles, disp_ready=host_ready=0 and mem_addr=0.
  - A grant issued in the same cycle as reset produces no valid.
- Simultaneous requests at starve_cnt < STARVE_LIMIT: display wins.
- Host worst-case wait with continuous disp_req: STARVE_LIMIT cycles, granted in cycle STARVE_LIMIT+1.

## Structure
- Package screen_mem_pkg: owner_t enum (OWN_NONE, OWN_DISP, OWN_HOST), default DATA_WIDTH/ADDR_WIDTH/COLS/ROWS constants.
- One sub-module: scroll_addr_map (combinational logical→physical address with wrap), so it can be unit-tested alone.
- The arbiter core holds starve_cnt, the owner decode, and the registered data/valid outputs.

## Test plan
- Host only: host_req=1, host_addr=5, mem holds 0x41 at 5 → host_ready in N, host_valid=1 and host_data=0x41 in N+1, disp_valid=0.
- Scroll wrap: scroll_row=24, disp_addr=80 → mem_addr=(80+1920)−2000=0. With scroll_row=30 → mem_addr=80.
- Contention: disp_req and host_req held high for 10 cycles → grants D,D,D,D,H,D,D,D,D,H. Each host grant is followed by host_valid next cycle.
- Simultaneous single requests at starve_cnt=0 → disp_ready=1, host_ready=0. The host is granted the next cycle after disp_req drops.
- Reset mid-operation: assert reset in the grant cycle of a host read → host_valid stays 0 next cycle, all data outputs read 0, and starve_cnt restarts from 0.
- Idle: both req low → mem_addr=0, both ready=0, and both valid=0 the next cycle.
